// File: rtl/decode_result_arbiter.sv
// -----------------------------------------------------------------------------
// decode_result_arbiter
//
// Merges the results of several format-specific decoders into one stream
// toward the dispatch stage. Each decoder source owns a single holding slot.
// Every cycle the occupied slot with the smallest major instruction ID is
// forwarded through a registered output stage. A source sees back-pressure
// whenever its slot is full and is not being drained in the same cycle.
//
// Ports
//   clock_i      : clock
//   reset_i      : synchronous active-high reset
//   valid_i      : per-source result valid
//   payload_i    : per-source payload, source k at [k*payloadWidth +: payloadWidth]
//   majId_i      : per-source major ID, packed the same way as payload_i
//   stall_i      : downstream cannot accept a result this cycle
//   stall_o      : per-source back-pressure (source holds valid/payload)
//   enable_o     : registered output valid
//   payload_o    : registered forwarded payload
//   majId_o      : registered forwarded major ID
//   sourceId_o   : registered index of the winning source
//   occupancy_o  : number of occupied slots (reflects state after the edge)
// -----------------------------------------------------------------------------
module decode_result_arbiter #(
    parameter int numSources              = 4,
    parameter int sourceIdWidth           = 2,
    parameter int payloadWidth            = 128,
    parameter int instructionCounterWidth = 64
) (
    input  logic                                          clock_i,
    input  logic                                          reset_i,
    input  logic [numSources-1:0]                         valid_i,
    input  logic [numSources*payloadWidth-1:0]            payload_i,
    input  logic [numSources*instructionCounterWidth-1:0] majId_i,
    input  logic                                          stall_i,
    output logic [numSources-1:0]                         stall_o,
    output logic                                          enable_o,
    output logic [payloadWidth-1:0]                       payload_o,
    output logic [instructionCounterWidth-1:0]            majId_o,
    output logic [sourceIdWidth-1:0]                      sourceId_o,
    output logic [sourceIdWidth:0]                        occupancy_o
);

    // -------------------------------------------------------------------------
    // Holding slots
    // -------------------------------------------------------------------------
    logic [numSources-1:0]              r_slot_valid;
    logic [payloadWidth-1:0]            r_slot_payload [numSources];
    logic [instructionCounterWidth-1:0] r_slot_maj_id  [numSources];

    // Unpacked views of the packed input buses
    logic [payloadWidth-1:0]            w_in_payload [numSources];
    logic [instructionCounterWidth-1:0] w_in_maj_id  [numSources];

    // Per-source handshake
    logic [numSources-1:0]              w_grant;
    logic [numSources-1:0]              w_capture;

    // Selection result
    logic                               w_any;
    logic [sourceIdWidth-1:0]           w_sel_idx;
    logic [instructionCounterWidth-1:0] w_sel_maj_id;
    logic [payloadWidth-1:0]            w_sel_payload;

    // Output registers
    logic                               r_enable;
    logic [payloadWidth-1:0]            r_payload;
    logic [instructionCounterWidth-1:0] r_maj_id;
    logic [sourceIdWidth-1:0]           r_source_id;

    logic [sourceIdWidth:0]             w_occupancy;

    // -------------------------------------------------------------------------
    // Input unpacking and per-source handshake
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < numSources; gi++) begin : g_src
            assign w_in_payload[gi] = payload_i[gi*payloadWidth +: payloadWidth];
            assign w_in_maj_id[gi]  = majId_i[gi*instructionCounterWidth +: instructionCounterWidth];

            // Only the selected slot can be granted, and only when downstream
            // accepts; this guarantees a one-hot (or empty) grant vector.
            assign w_grant[gi] = w_any & ~stall_i &
                                 (w_sel_idx == sourceIdWidth'(gi));

            // A full slot that is drained this cycle can be refilled on the
            // same edge, which is what lets a single source stream at one
            // result per cycle.
            assign stall_o[gi]   = r_slot_valid[gi] & ~w_grant[gi];
            assign w_capture[gi] = valid_i[gi] & ~stall_o[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Selection: smallest major ID among occupied slots. The scan runs from
    // source 0 upward with a strict less-than, so equal IDs keep the lower
    // source index. IDs are compared as plain unsigned numbers; wrap-around
    // of the instruction counter is not considered.
    // -------------------------------------------------------------------------
    always_comb begin
        w_any         = 1'b0;
        w_sel_idx     = '0;
        w_sel_maj_id  = '0;
        w_sel_payload = '0;
        for (int k = 0; k < numSources; k++) begin
            if (r_slot_valid[k] && (!w_any || (r_slot_maj_id[k] < w_sel_maj_id))) begin
                w_any         = 1'b1;
                w_sel_idx     = sourceIdWidth'(k);
                w_sel_maj_id  = r_slot_maj_id[k];
                w_sel_payload = r_slot_payload[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Slot valid bits. Capture takes priority over the clear caused by a
    // grant so that drain-and-refill on one edge leaves the slot occupied.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_slot_valid <= '0;
        end else begin
            for (int k = 0; k < numSources; k++) begin
                if (w_capture[k]) begin
                    r_slot_valid[k] <= 1'b1;
                end else if (w_grant[k]) begin
                    r_slot_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Slot data needs no reset: it is only ever observed while its valid bit
    // is set, and reset clears every valid bit, discarding in-flight entries.
    always_ff @(posedge clock_i) begin
        for (int k = 0; k < numSources; k++) begin
            if (w_capture[k]) begin
                r_slot_payload[k] <= w_in_payload[k];
                r_slot_maj_id[k]  <= w_in_maj_id[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output stage. While downstream stalls everything holds, including the
    // valid flag, so the consumer sees a stable result until it accepts.
    // When no slot is occupied only the valid flag drops; the data fields
    // keep the last forwarded result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_enable    <= 1'b0;
            r_payload   <= '0;
            r_maj_id    <= '0;
            r_source_id <= '0;
        end else if (!stall_i) begin
            r_enable <= w_any;
            if (w_any) begin
                r_payload   <= w_sel_payload;
                r_maj_id    <= w_sel_maj_id;
                r_source_id <= w_sel_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy: population count of the slot valid register, so it always
    // reflects the state left by the most recent edge.
    // -------------------------------------------------------------------------
    always_comb begin
        w_occupancy = '0;
        for (int k = 0; k < numSources; k++) begin
            w_occupancy = w_occupancy + (sourceIdWidth+1)'(r_slot_valid[k]);
        end
    end

    assign enable_o    = r_enable;
    assign payload_o   = r_payload;
    assign majId_o     = r_maj_id;
    assign sourceId_o  = r_source_id;
    assign occupancy_o = w_occupancy;

endmodule

// File: doc/decode_result_arbiter.md
Name: decode_result_arbiter

Overview:
- Merges results from up to 4 format-specific decoders (D, X, etc.) into a single in-order stream toward the dispatch stage.
- Each source gets a 1-entry holding slot.
- Each cycle the arbiter forwards the held result with the lowest major ID, and back-pressures sources whose slot cannot accept new data.
- Sits between the format-specific decoders and the decode-output/dispatch queue.

Parameters:
- numSources, 4, number of decoder sources (2..8)
- sourceIdWidth, 2, log2(numSources)
- payloadWidth, 128, packed decoded-instruction bundle (opcode, unit type, operands, body)
- instructionCounterWidth, 64, width of the major instruction ID

Ports:
- clock_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- valid_i  in  numSources  per-source result valid (decoder enable_o)
- payload_i  in  numSources*payloadWidth  per-source payload; source k occupies bits [k*payloadWidth +: payloadWidth]
- majId_i  in  numSources*instructionCounterWidth  per-source major ID, packed the same way
- stall_i  in  1  downstream cannot accept this cycle
- stall_o  out  numSources  per-source back-pressure; source must hold its valid/payload while asserted
- enable_o  out  1  output result valid
- payload_o  out  payloadWidth  forwarded payload
- majId_o  out  instructionCounterWidth  forwarded major ID
- sourceId_o  out  sourceIdWidth  index of the winning source
- occupancy_o  out  sourceIdWidth+1  number of occupied slots

Behaviour:
- State:
  - per source: slotValid, slotPayload, slotMajId
  - output registers: enable_o, payload_o, majId_o, sourceId_o
- Reset (synchronous, any cycle, including mid-operation):
  - all slotValid=0; enable_o=0; payload_o=0; majId_o=0; sourceId_o=0; occupancy_o=0
  - in-flight slot contents are discarded
- Selection (combinational, per cycle): among occupied slots, pick the smallest slotMajId (unsigned compare, no wrap handling). Ties go to the lowest source index.
- Grant: grant[k]=1 when slot k is selected and stall_i=0. At most one grant per cycle.
- Output register update at the clock edge:
  - stall_i=0 and some slot occupied: enable_o<=1; payload_o/majId_o/sourceId_o <= the selected slot's contents.
  - stall_i=0 and no slot occupied: enable_o<=0; the data outputs hold their last value.
  - stall_i=1: all output registers hold, including enable_o.
- Slot update at the clock edge, per source k:
  - granted: slot cleared.
  - valid_i[k]=1 and (slot empty or granted this cycle): slot captures payload_i/majId_i and slotValid<=1. A same-cycle drain and refill is allowed and gives full throughput.
  - valid_i[k]=1 while stall_o[k]=1: input ignored. The source holds it and retries.
- stall_o[k] (combinational) = slotValid[k] & ~grant[k].
- Latency: a result presented at edge N (captured) appears on enable_o after edge N+1 if it wins and stall_i=0. Minimum latency is 2 cycles from valid_i to enable_o.
- Throughput: 1 result per cycle total.
- Ordering:
  - The output is ordered by major ID among results held at the same time.
  - A younger result captured earlier may leave before an older one arrives. The downstream reorder logic tolerates this; the arbiter does not wait.
- occupancy_o: popcount of slotValid, registered view, i.e. after the edge.
- Simultaneous events on the same edge (capture on one source, grant on another, stall_i toggling) resolve independently per the rules above.

Test Plan:
- Reset mid-traffic: fill all 4 slots (majIds 7,3,9,5), assert reset_i for 1 cycle -> next cycle occupancy_o=0, enable_o=0, stall_o=0000; old entries never appear on the output.
- Ordering: a single cycle with valid_i=1111, majIds {7,3,9,5}, stall_i=0 -> enable_o high for 4 consecutive cycles with majId_o 3,5,7,9 and sourceId_o 1,3,0,2; stall_o for source 2 stays high until its grant cycle.
- Tie-break: sources 1 and 2 present majId=12 in the same cycle -> source 1 is output first, then source 2.
- Streaming: source 0 presents a new result every cycle (majId 0..15), other sources idle, stall_i=0 -> stall_o[0] never asserts; 16 consecutive enable_o pulses in order; first pulse 2 cycles after the first valid_i.
- Downstream stall: hold stall_i=1 for 5 cycles while sources 0 and 3 present majIds 4 and 2 -> enable_o, majId_o and payload_o frozen; stall_o=1001 throughout; after release, output 2 then 4.
- Back-pressure retry: source 2 holds valid_i with majId 20 while its slot holds majId 20-cycle-earlier entry 30 and older entries exist in other slots -> the new input is not captured until the cycle slot 2 is granted; capture then occurs the same cycle (no bubble).
